div_iter: RTL and testbench
===========================

Name: div_iter

Overview:
- Multi-cycle radix-2 restoring divider in the execute stage of the 5-stage MIPS core.
- Implements DIV/DIVU and produces the HI (remainder) and LO (quotient) results.
- Drives the execute-stage divide stall into the hazard unit (div_stallE), which freezes F/D/E/M/W while a divide is in flight.
- Takes the exception flush so that a cancelled divide is abandoned.

Parameters:
- WIDTH, 32, operand/result width in bits
- CNT_W, 6, width of the iteration counter; must satisfy 2^CNT_W > WIDTH

Ports:
- clk  in  1  core clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  valid divide instruction in E (div op decoded and not bubbled)
- signed_div  in  1  1 = DIV (two's complement), 0 = DIVU
- a  in  WIDTH  dividend (forwarded rs value)
- b  in  WIDTH  divisor (forwarded rt value)
- flush  in  1  exception flush of E (is_exceptM); abandons the operation
- ext_stall  in  1  other pipeline-wide stall (instrStall | dataStall)
- div_stall  out  1  to hazard unit: hold the pipeline
- ready  out  1  result valid this cycle
- hi  out  WIDTH  remainder
- lo  out  WIDTH  quotient

Behaviour:
- States: IDLE, BUSY, DONE.
- Reset: state=IDLE, count=0, hi=0, lo=0, ready=0, div_stall=0.
- IDLE:
  - div_stall = start & ~flush (combinational).
  - On start & ~flush: latch |a|, |b| (absolute values only when signed_div), sign_q = a[msb]^b[msb], sign_r = a[msb], signed_div; clear the 33-bit partial remainder; count=0; go to BUSY.
- BUSY:
  - Each cycle: shift the dividend MSB into the partial remainder, trial-subtract the divisor; if the result is non-negative, keep it and set the quotient bit to 1, else restore.
  - count increments; after iteration count==WIDTH-1, go to DONE.
  - div_stall=1 throughout.
- DONE:
  - ready=1, div_stall=0; hi/lo hold the sign-corrected results.
  - Sign correction: lo negated if sign_q & signed_div; hi negated if sign_r & signed_div.
  - If ext_stall, stay in DONE (results stable, no restart). Otherwise return to IDLE.
  - IDLE ignores start for the cycle it is entered from DONE, because start is still high for the same instruction. A one-bit "consumed" flag is cleared when E advances.
- Latency: start sampled in cycle T; BUSY T+1..T+WIDTH; DONE at T+WIDTH+1. div_stall is high from T through T+WIDTH (33 cycles for WIDTH=32).
- flush in any state: next state IDLE; ready and div_stall drop in the same cycle (combinational gating); hi/lo keep their previous committed values.
- flush takes priority over start when both are asserted in the same cycle.
- Divide by zero:
  - Unsigned: lo=all ones, hi=a.
  - Signed: magnitude quotient all ones, then the sign rules above apply.
  - No trap is raised.
- Overflow: 0x80000000 / 0xFFFFFFFF signed gives lo=0x80000000 and hi=0 (wraps).
- Reset mid-operation returns to IDLE immediately, asynchronously.

Optional Feature:
- Macro: DIV_ZERO_FAST_EN.
- Defined: in IDLE, start with b==0 goes directly to DONE at T+1 and loads the divide-by-zero results defined above; div_stall is high only in cycle T.
- Undefined: b==0 runs the full WIDTH iterations; the final values are identical, only latency differs.

Decomposition:
- Shared package core_pkg:
  - div_state_t enum (IDLE/BUSY/DONE)
  - DIV_ITERS constant (=WIDTH)
- Natural sub-module: div_step, a combinational single iteration.
  - Inputs: partial remainder, divisor, incoming bit.
  - Outputs: next remainder, quotient bit.
  - Instantiated once in div_iter.

Test Plan:
- Unsigned 100/7, start for one instruction -> div_stall high 33 cycles, then ready=1 with lo=14 (0x0000000E), hi=2.
- Signed a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Signed overflow 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Unsigned 5/0 -> lo=0xFFFFFFFF, hi=5; with DIV_ZERO_FAST_EN, ready at T+1 and div_stall high one cycle.
- Flush at BUSY iteration 10 -> div_stall=0 and ready=0 same cycle, state IDLE, hi/lo unchanged. A new start of 9/3 then gives lo=3, hi=0.
- ext_stall held 4 cycles while in DONE -> ready stays 1, hi/lo stable, no second divide. After release, returns to IDLE and does not restart on the same start.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: divider FSM states and iteration count.
package core_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_ITERS = 32;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract, restore on borrow.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   remIn,
    input  logic [WIDTH-1:0] divisor,
    input  logic             bitIn,
    output logic [WIDTH:0]   remOut,
    output logic             qBit
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    // One guard bit above the partial remainder makes the borrow visible as the MSB.
    assign shifted = {remIn, bitIn};
    assign diff    = shifted - {2'b00, divisor};
    assign qBit    = ~diff[WIDTH+1];
    assign remOut  = (WIDTH+1)'(qBit ? diff : shifted);

endmodule

// File: rtl/div_iter.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in the execute stage.
// Optional DIV_ZERO_FAST_EN: a zero divisor skips the iterations and finishes in one cycle.
module div_iter
    import core_pkg::*;
#(
    parameter int WIDTH = DIV_ITERS,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             ext_stall,
    output logic             div_stall,
    output logic             ready,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    div_state_t       state;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH:0]   rem;
    logic             signQ;
    logic             signR;
    logic             signedOp;
    logic             consumed;

    logic [WIDTH-1:0] absA;
    logic [WIDTH-1:0] absB;
    logic [WIDTH:0]   remNext;
    logic             qBit;
    logic [WIDTH-1:0] quotRaw;
    logic [WIDTH-1:0] remRaw;
    logic [WIDTH-1:0] quotFinal;
    logic [WIDTH-1:0] remFinal;
    logic             lastIter;

    assign absA = (signed_div && a[WIDTH-1]) ? -a : a;
    assign absB = (signed_div && b[WIDTH-1]) ? -b : b;

    div_step #(.WIDTH(WIDTH)) u_step (
        .remIn  (rem),
        .divisor(dvs),
        .bitIn  (dvd[WIDTH-1]),
        .remOut (remNext),
        .qBit   (qBit)
    );

    // dvd doubles as the quotient register: dividend bits leave at the top, quotient bits enter at the bottom.
    assign quotRaw   = {dvd[WIDTH-2:0], qBit};
    assign remRaw    = WIDTH'(remNext);
    assign quotFinal = (signQ && signedOp) ? -quotRaw : quotRaw;
    assign remFinal  = (signR && signedOp) ? -remRaw : remRaw;
    assign lastIter  = (count == CNT_W'(WIDTH - 1));

`ifdef DIV_ZERO_FAST_EN
    logic [WIDTH-1:0] zeroLo;
    assign zeroLo = (signed_div && a[WIDTH-1]) ? WIDTH'(1) : '1;
`endif

    // Handshake: start is a level held by E until the pipeline advances; ready is high for
    // every DONE cycle, and both ready and div_stall are killed combinationally by flush.
    assign div_stall = ~flush & (((state == IDLE) & start & ~consumed) | (state == BUSY));
    assign ready     = ~flush & (state == DONE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            count    <= '0;
            dvd      <= '0;
            dvs      <= '0;
            rem      <= '0;
            signQ    <= 1'b0;
            signR    <= 1'b0;
            signedOp <= 1'b0;
            consumed <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else if (flush) begin
            state    <= IDLE;
            consumed <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // The instruction that just finished may still be in E; wait for it to leave.
                    if (!ext_stall) consumed <= 1'b0;
                    if (start && !consumed) begin
                        dvd      <= absA;
                        dvs      <= absB;
                        rem      <= '0;
                        count    <= '0;
                        signQ    <= a[WIDTH-1] ^ b[WIDTH-1];
                        signR    <= a[WIDTH-1];
                        signedOp <= signed_div;
                        state    <= BUSY;
`ifdef DIV_ZERO_FAST_EN
                        if (b == '0) begin
                            hi    <= a;
                            lo    <= zeroLo;
                            state <= DONE;
                        end
`endif
                    end
                end
                BUSY: begin
                    rem   <= remNext;
                    dvd   <= quotRaw;
                    count <= count + 1'b1;
                    if (lastIter) begin
                        hi    <= remFinal;
                        lo    <= quotFinal;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (!ext_stall) begin
                        state    <= IDLE;
                        consumed <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed corner cases plus randomized divides against an arithmetic model.
module tb_div_iter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         resetn;
    logic         start;
    logic         signed_div;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         flush;
    logic         ext_stall;
    logic         div_stall;
    logic         ready;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [63:0]  exp_q[$];
    logic [63:0]  last_hl = '0;

    div_iter dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .signed_div(signed_div),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .ext_stall (ext_stall),
        .div_stall (div_stall),
        .ready     (ready),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference: plain integer division; signed uses 64-bit truncating division.
    function automatic logic [63:0] ref_div(input logic [W-1:0] x, input logic [W-1:0] y, input logic sd);
        logic [W-1:0] q;
        logic [W-1:0] r;
        longint       sx;
        longint       sy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (y == 0) begin
            r = x;
            q = (sd && sx < 0) ? W'(1) : '1;
        end else if (!sd) begin
            q = x / y;
            r = x % y;
        end else begin
            q = W'(sx / sy);
            r = W'(sx % sy);
        end
        return {r, q};
    endfunction

    function automatic int exp_stall_cycles(input logic [W-1:0] y);
`ifdef DIV_ZERO_FAST_EN
        if (y == 0) return 1;
`endif
        return W + 1;
    endfunction

    task automatic run_div(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sd, input int ext_cycles);
        logic [63:0] exp;
        int          stalls;
        bit          got;
        exp_q.push_back(ref_div(av, bv, sd));
        @(negedge clk);
        a = av; b = bv; signed_div = sd; start = 1'b1;
        #1;
        stalls = 0;
        got    = 1'b0;
        for (int c = 0; c < W + 10; c++) begin
            if (ready) begin
                got = 1'b1;
                break;
            end
            if (div_stall) stalls++;
            @(negedge clk);
            #1;
        end
        exp = exp_q.pop_front();
        if (!got) begin
            check_eq("ready_timeout", 64'd0, 64'd1);
        end else begin
            check_eq("stall_cycles", 64'(stalls), 64'(exp_stall_cycles(bv)));
            check_eq("stall_in_done", 64'(div_stall), 64'd0);
            check_eq("hi", 64'(hi), 64'(exp[63:32]));
            check_eq("lo", 64'(lo), 64'(exp[31:0]));
            last_hl = exp;
            ext_stall = (ext_cycles > 0);
            for (int k = 0; k < ext_cycles; k++) begin
                @(negedge clk);
                #1;
                check_eq("hold_ready", 64'(ready), 64'd1);
                check_eq("hold_stall", 64'(div_stall), 64'd0);
                check_eq("hold_hilo", {hi, lo}, exp);
            end
            ext_stall = 1'b0;
            @(negedge clk);
            #1;
            check_eq("no_restart_stall", 64'(div_stall), 64'd0);
            check_eq("no_restart_ready", 64'(ready), 64'd0);
            check_eq("idle_hilo", {hi, lo}, exp);
        end
        start = 1'b0;
    endtask

    initial begin
        int act_cnt;
        resetn = 1'b0; start = 1'b0; signed_div = 1'b0; a = '0; b = '0;
        flush = 1'b0; ext_stall = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_hi", 64'(hi), 64'd0);
        check_eq("rst_lo", 64'(lo), 64'd0);
        check_eq("rst_ready", 64'(ready), 64'd0);
        check_eq("rst_stall", 64'(div_stall), 64'd0);
        @(negedge clk);
        resetn = 1'b1;

        run_div(32'd100, 32'd7, 1'b0, 0);
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 0);
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
        run_div(32'd5, 32'd0, 1'b0, 0);
        run_div(32'hFFFF_FF00, 32'd0, 1'b1, 0);
        run_div(32'd77, 32'd0, 1'b1, 0);

        // Flush at BUSY iteration 10: cycle T+11 after the start cycle.
        @(negedge clk);
        a = 32'd100; b = 32'd7; signed_div = 1'b0; start = 1'b1;
        repeat (11) @(negedge clk);
        #1;
        check_eq("busy_stall", 64'(div_stall), 64'd1);
        flush = 1'b1;
        #1;
        check_eq("flush_stall", 64'(div_stall), 64'd0);
        check_eq("flush_ready", 64'(ready), 64'd0);
        check_eq("flush_hilo", {hi, lo}, last_hl);
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        #1;
        check_eq("post_flush_stall", 64'(div_stall), 64'd0);
        check_eq("post_flush_hilo", {hi, lo}, last_hl);
        run_div(32'd9, 32'd3, 1'b0, 0);

        // Flush beats start in IDLE: no divide may begin.
        @(negedge clk);
        a = 32'd20; b = 32'd3; start = 1'b1; flush = 1'b1;
        #1;
        check_eq("flush_prio_stall", 64'(div_stall), 64'd0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        act_cnt = 0;
        for (int c = 0; c < W + 8; c++) begin
            @(negedge clk);
            #1;
            if (ready || div_stall) act_cnt++;
        end
        check_eq("flush_prio_idle", 64'(act_cnt), 64'd0);

        run_div(32'd1000, 32'd33, 1'b0, 4);
        run_div(32'hFFFF_FC18, 32'd7, 1'b1, 2);

        for (int i = 0; i < 25; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = $urandom;
            case ($urandom_range(0, 4))
                0: rb = 32'd0;
                1: rb = W'($urandom_range(1, 15));
                2: rb = 32'hFFFF_FFFF;
                3: rb = W'(-$urandom_range(1, 100));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
            run_div(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end

        // Asynchronous reset in the middle of a divide.
        @(negedge clk);
        a = 32'd500; b = 32'd3; signed_div = 1'b0; start = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        start = 1'b0;
        resetn = 1'b0;
        #1;
        check_eq("midrst_stall", 64'(div_stall), 64'd0);
        check_eq("midrst_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        run_div(32'd17, 32'd5, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
